// File: rtl/goc_pwm_tx_if.sv
// FIFO write port of the GOC PWM transmitter: data/strobe from the bus side,
// occupancy and overflow status back to it.
interface goc_pwm_tx_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              fifo_full;
    logic [LVL_W-1:0]  fifo_level;
    logic              wr_overflow;

    modport master (
        output wr_data,
        output wr_en,
        input  fifo_full,
        input  fifo_level,
        input  wr_overflow
    );

    modport slave (
        input  wr_data,
        input  wr_en,
        output fifo_full,
        output fifo_level,
        output wr_overflow
    );
endinterface

// File: rtl/goc_pwm_tx.sv
// GOC optical transmitter: buffers words in a FIFO and sends them as three-slot
// PWM bits (1 / bit / 0) framed by a '1' preamble and a low stop period.
module goc_pwm_tx #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned SPEED_W       = 22,
    parameter int unsigned PREAMBLE_BITS = 4,
    parameter int unsigned STOP_SLOTS    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] goc_speed,
    input  logic               goc_polarity,
    input  logic               msb_first,
    goc_pwm_tx_if.slave        wr_bus,
    input  logic               start_tx,
    input  logic               abort,
    output logic               busy,
    output logic               tx_done,
    output logic [15:0]        byte_count,
    output logic               GOC_PAD
);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = AW + 1;
    localparam int unsigned MAX_A   = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
    localparam int unsigned MAX_CNT = (MAX_A > STOP_SLOTS) ? MAX_A : STOP_SLOTS;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_SLOTS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t              state, state_n;
    logic [SPEED_W-1:0]  spd, spd_n;
    logic [SPEED_W-1:0]  slot_cnt, slot_cnt_n;
    logic [1:0]          slot_idx, slot_idx_n;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic                msb_r, msb_n;
    logic                line, line_n;
    logic                tx_done_n;
    logic [15:0]         byte_cnt_n;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LVL_W-1:0]    count;
    logic                overflow;

    logic                full, word_first, pop, push, flush, slot_end, cur_bit;
    logic [DATA_W-1:0]   head, src_data;
    logic                src_msb;

    assign full       = (count == LVL_FULL);
    assign head       = mem[rd_ptr];
    assign slot_end   = (slot_cnt == spd);
    assign word_first = (state == ST_DATA) && (slot_idx == 2'd0) &&
                        (bit_cnt == '0) && (slot_cnt == '0);
    assign pop        = word_first && (count != '0) && !abort;
    assign push       = wr_bus.wr_en && !abort && (!full || pop);
    assign flush      = abort;

    // The head is popped in the same cycle that a 1-cycle slot A may end, so bypass it.
    assign src_data = word_first ? head : shreg;
    assign src_msb  = word_first ? msb_first : msb_r;
    assign cur_bit  = src_msb ? src_data[DATA_W-1] : src_data[0];

    assign wr_bus.fifo_full   = full;
    assign wr_bus.fifo_level  = count;
    assign wr_bus.wr_overflow = overflow;
    assign GOC_PAD            = line ^ goc_polarity;

    // Next-state, slot sequencing and next line value
    always_comb begin
        state_n    = state;
        spd_n      = spd;
        slot_cnt_n = slot_end ? '0 : slot_cnt + SPEED_W'(1);
        slot_idx_n = slot_idx;
        bit_cnt_n  = bit_cnt;
        shreg_n    = pop ? head : shreg;
        msb_n      = pop ? msb_first : msb_r;
        line_n     = line;
        byte_cnt_n = byte_count;

        case (state)
            ST_IDLE: begin
                slot_cnt_n = '0;
                line_n     = 1'b0;
                if (!abort && start_tx && (count != '0)) begin
                    spd_n      = goc_speed;
                    byte_cnt_n = '0;
                    slot_idx_n = 2'd0;
                    bit_cnt_n  = '0;
                    line_n     = 1'b1;
                    state_n    = (PREAMBLE_BITS > 0) ? ST_PREAMBLE : ST_DATA;
                end
            end
            ST_PREAMBLE: begin
                if (slot_end) begin
                    case (slot_idx)
                        2'd0: begin
                            slot_idx_n = 2'd1;
                            line_n     = 1'b1;
                        end
                        2'd1: begin
                            slot_idx_n = 2'd2;
                            line_n     = 1'b0;
                        end
                        default: begin
                            slot_idx_n = 2'd0;
                            line_n     = 1'b1;
                            if (bit_cnt == PRE_LAST) begin
                                bit_cnt_n = '0;
                                state_n   = ST_DATA;
                            end else begin
                                bit_cnt_n = bit_cnt + CNT_W'(1);
                            end
                        end
                    endcase
                end
            end
            ST_DATA: begin
                if (slot_end) begin
                    case (slot_idx)
                        2'd0: begin
                            slot_idx_n = 2'd1;
                            line_n     = cur_bit;
                        end
                        2'd1: begin
                            slot_idx_n = 2'd2;
                            line_n     = 1'b0;
                        end
                        default: begin
                            slot_idx_n = 2'd0;
                            shreg_n    = msb_r ? {shreg[DATA_W-2:0], 1'b0}
                                               : {1'b0, shreg[DATA_W-1:1]};
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt_n  = '0;
                                byte_cnt_n = (byte_count != 16'hFFFF) ? byte_count + 16'd1
                                                                      : byte_count;
                                if (count != '0) begin
                                    line_n = 1'b1;
                                end else begin
                                    line_n  = 1'b0;
                                    state_n = ST_STOP;
                                end
                            end else begin
                                bit_cnt_n = bit_cnt + CNT_W'(1);
                                line_n    = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                line_n = 1'b0;
                if (slot_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = ST_IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
        endcase

        if (abort && (state != ST_IDLE)) begin
            state_n    = ST_IDLE;
            line_n     = 1'b0;
            slot_cnt_n = '0;
            slot_idx_n = 2'd0;
            bit_cnt_n  = '0;
            byte_cnt_n = byte_count;
        end

        // Registered pulse lands on the last STOP cycle
        tx_done_n = (state_n == ST_STOP) && (bit_cnt_n == STOP_LAST) && (slot_cnt_n == spd_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            spd        <= '0;
            slot_cnt   <= '0;
            slot_idx   <= 2'd0;
            bit_cnt    <= '0;
            shreg      <= '0;
            msb_r      <= 1'b0;
            line       <= 1'b0;
            tx_done    <= 1'b0;
            busy       <= 1'b0;
            byte_count <= '0;
        end else begin
            state      <= state_n;
            spd        <= spd_n;
            slot_cnt   <= slot_cnt_n;
            slot_idx   <= slot_idx_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            msb_r      <= msb_n;
            line       <= line_n;
            tx_done    <= tx_done_n;
            busy       <= (state_n != ST_IDLE);
            byte_count <= byte_cnt_n;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_bus.wr_en && full && !pop) begin
                overflow <= 1'b1;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + LVL_W'(1);
                    2'b01:   count <= count - LVL_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_bus.wr_data;
        end
    end
endmodule

// File: tb/tb_goc_pwm_tx.sv
// Directed bench for goc_pwm_tx: framing, slot timing, FIFO limits, abort and reset.
module tb_goc_pwm_tx;
    logic        clk;
    logic        reset;
    logic [21:0] goc_speed;
    logic        goc_polarity;
    logic        msb_first;
    logic        start_tx;
    logic        abort;
    logic        busy;
    logic        tx_done;
    logic [15:0] byte_count;
    logic        GOC_PAD;

    int checks = 0;
    int errors = 0;

    goc_pwm_tx_if #(.DATA_W(8), .FIFO_DEPTH(8)) bus ();

    goc_pwm_tx #(
        .DATA_W(8), .FIFO_DEPTH(8), .SPEED_W(22), .PREAMBLE_BITS(4), .STOP_SLOTS(3)
    ) dut (
        .clk(clk), .reset(reset), .goc_speed(goc_speed), .goc_polarity(goc_polarity),
        .msb_first(msb_first), .wr_bus(bus), .start_tx(start_tx), .abort(abort),
        .busy(busy), .tx_done(tx_done), .byte_count(byte_count), .GOC_PAD(GOC_PAD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Expected line for busy cycle n: bits[nbits-1] is sent first, then stop slots
    function automatic logic exp_line(input int spd, input logic [63:0] bits,
                                      input int nbits, input int n);
        int bl, bi, sl;
        bl = 3 * (spd + 1);
        bi = n / bl;
        sl = (n % bl) / (spd + 1);
        if (bi >= nbits) return 1'b0;
        case (sl)
            0:       return 1'b1;
            1:       return bits[nbits - 1 - bi];
            default: return 1'b0;
        endcase
    endfunction

    // Starts a frame and follows it while busy; optional mid-frame write/speed change and abort
    task automatic run_frame(input int spd, input logic [63:0] bits, input int nbits,
                             input int evt_at, input logic [7:0] evt_word, input int abort_at,
                             output int cycles, output int errs, output int dones);
        int  n;
        logic e;
        n = 0; errs = 0; dones = 0;
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        while (busy && n < 2000) begin
            e = exp_line(spd, bits, nbits, n) ^ goc_polarity;
            if (GOC_PAD !== e) errs++;
            if (tx_done) dones++;
            if (n == evt_at) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = evt_word;
                goc_speed   = 22'd5;
            end
            if (n == abort_at) abort = 1'b1;
            n++;
            tick();
            bus.wr_en = 1'b0;
            abort     = 1'b0;
        end
        cycles = n;
    endtask

    int          cyc, errs, dn;
    logic [63:0] bits;

    initial begin
        reset = 1'b1; goc_speed = '0; goc_polarity = 1'b1; msb_first = 1'b1;
        start_tx = 1'b0; abort = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0;

        // Reset defaults
        do_reset();
        check("rst_pad", 32'(GOC_PAD), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(bus.fifo_level), 32'd0);
        check("rst_full", 32'(bus.fifo_full), 32'd0);
        check("rst_ovf", 32'(bus.wr_overflow), 32'd0);
        check("rst_bcnt", 32'(byte_count), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);

        // Single word 0xA5, MSB first, 2-cycle slots
        goc_polarity = 1'b0; goc_speed = 22'd1; msb_first = 1'b1;
        write_word(8'hA5);
        bits = 64'b1111_1010_0101;
        run_frame(1, bits, 12, -1, 8'h00, -1, cyc, errs, dn);
        check("one_wave", 32'(errs), 32'd0);
        check("one_busy", 32'(cyc), 32'd78);
        check("one_done", 32'(dn), 32'd1);
        check("one_bcnt", 32'(byte_count), 32'd1);
        check("one_pad_end", 32'(GOC_PAD), 32'd0);
        check("one_done_end", 32'(tx_done), 32'd0);

        // Back-to-back, LSB first, 4th word and a speed change mid-frame
        goc_speed = 22'd0; msb_first = 1'b0;
        write_word(8'h01); write_word(8'h80); write_word(8'h3C);
        bits = {28'h0, 4'b1111, 8'b1000_0000, 8'b0000_0001, 8'b0011_1100, 8'b0000_1111};
        run_frame(0, bits, 36, 20, 8'hF0, -1, cyc, errs, dn);
        check("b2b_wave", 32'(errs), 32'd0);
        check("b2b_busy", 32'(cyc), 32'd111);
        check("b2b_done", 32'(dn), 32'd1);
        check("b2b_bcnt", 32'(byte_count), 32'd4);
        goc_speed = 22'd0;

        // Full FIFO: write coincident with pop keeps level, no overflow
        goc_polarity = 1'b1;
        for (int i = 0; i < 8; i++) write_word(8'(i));
        check("full_level", 32'(bus.fifo_level), 32'd8);
        check("full_flag", 32'(bus.fifo_full), 32'd1);
        check("full_ovf0", 32'(bus.wr_overflow), 32'd0);
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        repeat (12) tick();
        bus.wr_en = 1'b1; bus.wr_data = 8'h77;
        tick();
        bus.wr_en = 1'b0;
        check("wrpop_level", 32'(bus.fifo_level), 32'd8);
        check("wrpop_ovf", 32'(bus.wr_overflow), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abt1_pad", 32'(GOC_PAD), 32'd1);
        check("abt1_busy", 32'(busy), 32'd0);
        check("abt1_level", 32'(bus.fifo_level), 32'd0);

        // Nine writes with no transmit: drop and sticky overflow, then idle abort flushes
        for (int i = 0; i < 9; i++) write_word(8'(8'h40 + i));
        check("ovf_level", 32'(bus.fifo_level), 32'd8);
        check("ovf_full", 32'(bus.fifo_full), 32'd1);
        check("ovf_flag", 32'(bus.wr_overflow), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abt_level", 32'(bus.fifo_level), 32'd0);
        check("idle_abt_full", 32'(bus.fifo_full), 32'd0);
        check("ovf_sticky", 32'(bus.wr_overflow), 32'd1);

        // Abort during word 2 of 3
        msb_first = 1'b1;
        write_word(8'h11); write_word(8'h22); write_word(8'h33);
        bits = {36'h0, 4'b1111, 8'h11, 8'h22, 8'h33};
        run_frame(0, bits, 28, -1, 8'h00, 45, cyc, errs, dn);
        check("abt_wave", 32'(errs), 32'd0);
        check("abt_busy", 32'(cyc), 32'd46);
        check("abt_done", 32'(dn), 32'd0);
        check("abt_pad", 32'(GOC_PAD), 32'd1);
        check("abt_level", 32'(bus.fifo_level), 32'd0);
        check("abt_bcnt", 32'(byte_count), 32'd1);
        check("abt_done_after", 32'(tx_done), 32'd0);

        // start_tx with an empty FIFO
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        check("empty_busy", 32'(busy), 32'd0);
        tick();
        check("empty_busy2", 32'(busy), 32'd0);
        check("empty_pad", 32'(GOC_PAD), 32'd1);

        // Reset in the middle of a frame
        write_word(8'hC3); write_word(8'h5A);
        start_tx = 1'b1;
        tick();
        start_tx = 1'b0;
        repeat (40) tick();
        check("mid_bcnt", 32'(byte_count), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_pad", 32'(GOC_PAD), 32'd1);
        check("mrst_level", 32'(bus.fifo_level), 32'd0);
        check("mrst_ovf", 32'(bus.wr_overflow), 32'd0);
        check("mrst_bcnt", 32'(byte_count), 32'd0);
        check("mrst_done", 32'(tx_done), 32'd0);
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
